hazard_scoreboard: RTL

//  Successor hazard unit for the 5-stage ARM pipeline, placed in ID beside the register file.

---
 rtl/hazard_pkg.sv | 41 ++++
 rtl/hazard_scoreboard_if.sv | 45 ++++
 rtl/hazard_scoreboard_pend_counter.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 73 +++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: forwarding select encoding and
// the per-source hazard/forward resolution used by the top level.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXE = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic     hazard;
    fwd_sel_t sel;
  } src_res_t;

  // Forwarding is only legal when exactly one writer is in flight; a load in EXE
  // fails both forward tests and so always ends up as a hazard.
  function automatic src_res_t resolve_src(
    input logic active,
    input logic eff_zero,
    input logic eff_one,
    input logic exe_match,
    input logic exe_load,
    input logic mem_match,
    input logic fwd_en
  );
    src_res_t res;
    res.hazard = 1'b0;
    res.sel    = FWD_RF;
    if (active && !eff_zero) begin
      if (fwd_en && eff_one && exe_match && !exe_load)
        res.sel = FWD_EXE;
      else if (fwd_en && eff_one && mem_match && !exe_match)
        res.sel = FWD_MEM;
      else
        res.hazard = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage view of the pipeline as seen by the hazard scoreboard.
// master = pipeline control, slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int PERF_W     = 16
);
  import hazard_pkg::*;

  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  use_src1;
  logic                  two_src;
  logic                  id_wb_en;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  issue;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic                  exe_wb_en;
  logic                  exe_mem_r_en;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  commit_valid;
  logic [REG_ADDR_W-1:0] commit_dest;
  logic                  kill_valid;
  logic [REG_ADDR_W-1:0] kill_dest;
  logic                  hazard_detected;
  fwd_sel_t              fwd_sel_a;
  fwd_sel_t              fwd_sel_b;
  logic                  err_underflow;
  logic [PERF_W-1:0]     stall_count;

  modport master (
    output src1, src2, use_src1, two_src, id_wb_en, id_dest, issue,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           commit_valid, commit_dest, kill_valid, kill_dest,
    input  hazard_detected, fwd_sel_a, fwd_sel_b, err_underflow, stall_count
  );

  modport slave (
    input  src1, src2, use_src1, two_src, id_wb_en, id_dest, issue,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           commit_valid, commit_dest, kill_valid, kill_dest,
    output hazard_detected, fwd_sel_a, fwd_sel_b, err_underflow, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_pend_counter.sv
// In-flight writer count for one architectural register. eff is the count after
// this cycle's commit/kill, so a same-cycle writeback is already visible to ID.
module pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec_c,
  input  logic              dec_k,
  output logic [PEND_W-1:0] count,
  output logic [PEND_W-1:0] eff,
  output logic              underflow
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] n_dec;
  logic [PEND_W-1:0] next;

  // Decrements beyond the remaining count are dropped and flagged.
  always_comb begin
    n_dec     = '0;
    underflow = 1'b0;
    if (count == '0) begin
      underflow = dec_c | dec_k;
    end else if (count == PEND_W'(1)) begin
      n_dec     = PEND_W'(dec_c | dec_k);
      underflow = dec_c & dec_k;
    end else begin
      n_dec = PEND_W'(dec_c) + PEND_W'(dec_k);
    end
    eff  = count - n_dec;
    next = (inc && eff != CNT_MAX) ? eff + PEND_W'(1) : eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= next;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register scoreboard of in-flight writes, EXE/MEM
// forwarding select, load-use and saturation stalls, sticky underflow and stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int PEND_W     = 2,
  parameter int FORWARD_EN = 1,
  parameter int PERF_W     = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave sb
);

  localparam int                NUM_REGS = 2 ** REG_ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend [NUM_REGS];
  logic [PEND_W-1:0] eff  [NUM_REGS];
  logic [NUM_REGS-1:0] uflow;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    pend_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (sb.issue && sb.id_wb_en && sb.id_dest == REG_ADDR_W'(r)),
      .dec_c     (sb.commit_valid && sb.commit_dest == REG_ADDR_W'(r)),
      .dec_k     (sb.kill_valid && sb.kill_dest == REG_ADDR_W'(r)),
      .count     (pend[r]),
      .eff       (eff[r]),
      .underflow (uflow[r])
    );
  end

  src_res_t          res_a;
  src_res_t          res_b;
  logic              sat;
  logic              hazard;
  logic              err_q;
  logic [PERF_W-1:0] stall_q;

  always_comb begin
    res_a = resolve_src(sb.use_src1,
                        eff[sb.src1] == '0, eff[sb.src1] == PEND_W'(1),
                        sb.exe_wb_en && sb.exe_dest == sb.src1, sb.exe_mem_r_en,
                        sb.mem_wb_en && sb.mem_dest == sb.src1, FORWARD_EN != 0);
    res_b = resolve_src(sb.two_src,
                        eff[sb.src2] == '0, eff[sb.src2] == PEND_W'(1),
                        sb.exe_wb_en && sb.exe_dest == sb.src2, sb.exe_mem_r_en,
                        sb.mem_wb_en && sb.mem_dest == sb.src2, FORWARD_EN != 0);
    // Saturation looks at the registered count so a writer never issues into a full slot.
    sat    = sb.id_wb_en && pend[sb.id_dest] == PEND_MAX;
    hazard = res_a.hazard | res_b.hazard | sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      if (|uflow) err_q <= 1'b1;
      if (hazard && stall_q != '1) stall_q <= stall_q + PERF_W'(1);
    end
  end

  assign sb.hazard_detected = hazard;
  assign sb.fwd_sel_a       = res_a.sel;
  assign sb.fwd_sel_b       = res_b.sel;
  assign sb.err_underflow   = err_q;
  assign sb.stall_count     = stall_q;

endmodule
